// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch pulse driver.
//   sr_state_t : FSM state encoding (idle, set pulse, reset pulse, gap)
//   CNT_W      : width of the pulse/gap cycle counter
//   cnt_load() : counter preload for an N-cycle interval (N-1, or 0 when N is 0)
package sr_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE_S,
    ST_PULSE_R,
    ST_GAP
  } sr_state_t;

  // The counter runs down to 0, so an N-cycle interval preloads N-1.
  function automatic cnt_t cnt_load(input int unsigned n);
    return (n == 0) ? '0 : cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/sr_pulse_driver.sv
// Drives an external SR latch with fixed-width active-low pulses.
// One command (set or reset) is accepted at a time. Each command produces a
// PULSE_W-cycle low pulse on S_n or R_n, then GAP_W idle cycles with both
// outputs high. With SKIP_REDUNDANT a command that matches the tracked
// latch state completes immediately without a pulse.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   cmd_valid : command request
//   cmd_set   : 1 = set latch (Q to 1), 0 = reset latch (Q to 0)
//   cmd_ready : command can be accepted this cycle (IDLE and out of reset)
//   S_n       : registered active-low set drive
//   R_n       : registered active-low reset drive
//   q_track   : latch state implied by the last completed command
//   done      : one-cycle strobe when a command completes
module sr_pulse_driver
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_W        = 4,
  parameter int unsigned GAP_W          = 2,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S_n,
  output logic R_n,
  output logic q_track,
  output logic done
);

  localparam cnt_t PULSE_LOAD = cnt_load(PULSE_W);
  localparam cnt_t GAP_LOAD   = cnt_load(GAP_W);

  sr_state_t state, next_state;
  cnt_t      cnt, cnt_next;
  logic      q_next;
  logic      done_next;
  logic      running;
  logic      accept;

  // running holds cmd_ready low while in reset and until the first clock edge
  // after rst_n rises.
  assign cmd_ready = running && (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    q_next     = q_track;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (SKIP_REDUNDANT && (cmd_set == q_track)) begin
            done_next = 1'b1;
          end else begin
            next_state = cmd_set ? ST_PULSE_S : ST_PULSE_R;
            cnt_next   = PULSE_LOAD;
          end
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        if (cnt == '0) begin
          // Last pulse cycle: the latch now holds the commanded value.
          q_next    = (state == ST_PULSE_S);
          done_next = 1'b1;
          if (GAP_W == 0) begin
            next_state = ST_IDLE;
            cnt_next   = '0;
          end else begin
            next_state = ST_GAP;
            cnt_next   = GAP_LOAD;
          end
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          next_state = ST_IDLE;
        end else begin
          cnt_next = cnt - cnt_t'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Drives are registered from next_state so they change in the same cycle
  // as the state, glitch-free, and can never both be low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      S_n     <= 1'b1;
      R_n     <= 1'b1;
      q_track <= 1'b0;
      done    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      S_n     <= (next_state != ST_PULSE_S);
      R_n     <= (next_state != ST_PULSE_R);
      q_track <= q_next;
      done    <= done_next;
      running <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Self-checking bench for sr_pulse_driver: a default instance (PULSE_W=4,
// GAP_W=2) and a fast instance (PULSE_W=1, GAP_W=0).
module tb_sr_pulse_driver;

  logic clk;
  logic rst_n;
  logic cmd_valid, cmd_set, cmd_ready, S_n, R_n, q_track, done;
  logic cmd_valid2, cmd_set2, cmd_ready2, S_n2, R_n2, q_track2, done2;

  int errors = 0;
  int checks = 0;

  // Expected q_track value for each accepted command, popped on done.
  logic sb[$];

  sr_pulse_driver #(.PULSE_W(4), .GAP_W(2), .SKIP_REDUNDANT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .S_n(S_n), .R_n(R_n), .q_track(q_track), .done(done)
  );

  sr_pulse_driver #(.PULSE_W(1), .GAP_W(0), .SKIP_REDUNDANT(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_set(cmd_set2),
    .cmd_ready(cmd_ready2), .S_n(S_n2), .R_n(R_n2), .q_track(q_track2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; record any command the main DUT accepts on that edge.
  task automatic step();
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) sb.push_back(cmd_set);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer and overlap monitor for the main DUT.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (S_n === 1'b0 && R_n === 1'b0) begin
        errors++;
        $display("FAIL overlap: S_n=%b R_n=%b both low at %0t", S_n, R_n, $time);
      end
      if (done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: done=1 with no pending command at %0t", $time);
        end else begin
          logic exp_q;
          exp_q = sb.pop_front();
          if (q_track !== exp_q) begin
            errors++;
            $display("FAIL sb_q_track: got %b expected %b at %0t", q_track, exp_q, $time);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_set = 1'b0;
    cmd_valid2 = 1'b0; cmd_set2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, S_n, R_n, q_track, done} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_outputs: ready,S_n,R_n,q,done=%b expected 01100",
               {cmd_ready, S_n, R_n, q_track, done});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || cmd_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_edge: got %b/%b expected 1/1", cmd_ready, cmd_ready2);
    end
  endtask

  task automatic test_set_sequence();
    logic exp_s, exp_d, exp_q, exp_r;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      exp_s = !(i >= 1 && i <= 4);
      exp_d = (i == 5);
      exp_q = (i >= 5);
      exp_r = (i == 7);
      checks++;
      if (S_n !== exp_s || R_n !== 1'b1 || done !== exp_d || q_track !== exp_q ||
          cmd_ready !== exp_r) begin
        errors++;
        $display("FAIL set_seq cycle %0d: S_n,R_n,done,q,ready=%b%b%b%b%b expected %b1%b%b%b",
                 i, S_n, R_n, done, q_track, cmd_ready, exp_s, exp_d, exp_q, exp_r);
      end
      if (i < 7) step();
    end
  endtask

  task automatic test_skip();
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || S_n !== 1'b1 || R_n !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL skip_cycle1: done,S_n,R_n,ready=%b%b%b%b expected 1111",
               done, S_n, R_n, cmd_ready);
    end
    step();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || q_track !== 1'b1) begin
      errors++;
      $display("FAIL skip_cycle2: done,ready,q=%b%b%b expected 011", done, cmd_ready, q_track);
    end
  endtask

  task automatic test_back_to_back();
    int s_fall, r_fall, s_low, r_low, wait_cnt;
    // Bring the latch to 0 first so the set is not redundant.
    cmd_valid = 1'b1; cmd_set = 1'b0;
    step();
    cmd_valid = 1'b0;
    wait_cnt = 0;
    while (cmd_ready !== 1'b1 && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || q_track !== 1'b0) begin
      errors++;
      $display("FAIL b2b_prep: ready=%b q=%b expected 1 0 within 20 cycles", cmd_ready, q_track);
    end

    s_fall = -1; r_fall = -1; s_low = 0; r_low = 0;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (S_n === 1'b0) begin
        s_low++;
        if (s_fall < 0) s_fall = c;
        cmd_set = 1'b0;
      end
      if (R_n === 1'b0) begin
        r_low++;
        if (r_fall < 0) r_fall = c;
        cmd_valid = 1'b0;
      end
    end
    checks++;
    if (s_fall < 0 || r_fall < 0 || (r_fall - s_fall) != 7) begin
      errors++;
      $display("FAIL b2b_spacing: S fall %0d R fall %0d, distance %0d expected 7",
               s_fall, r_fall, r_fall - s_fall);
    end
    checks++;
    if (s_low != 4 || r_low != 4) begin
      errors++;
      $display("FAIL b2b_widths: S low %0d R low %0d expected 4 4", s_low, r_low);
    end
    checks++;
    if (q_track !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final: q=%b ready=%b expected 0 1", q_track, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int wait_cnt;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_cnt = 0;
    while (cmd_ready !== 1'b1 && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || q_track !== 1'b1) begin
      errors++;
      $display("FAIL midrst_prep: ready=%b q=%b expected 1 1 within 20 cycles", cmd_ready, q_track);
    end

    cmd_valid = 1'b1; cmd_set = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if (R_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pulse: R_n=%b expected 0 in 2nd pulse cycle", R_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (R_n !== 1'b1 || S_n !== 1'b1 || q_track !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: R_n,S_n,q,done,ready=%b%b%b%b%b expected 11000",
               R_n, S_n, q_track, done, cmd_ready);
    end
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || q_track !== 1'b0 || R_n !== 1'b1) begin
        errors++;
        $display("FAIL midrst_after: done,ready,q,R_n=%b%b%b%b expected 0101",
                 done, cmd_ready, q_track, R_n);
      end
    end
  endtask

  task automatic test_ignore_busy();
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (S_n !== 1'b0 || R_n !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_pulse cycle %0d: S_n,R_n,ready=%b%b%b expected 010",
                 i, S_n, R_n, cmd_ready);
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_set   = 1'($urandom_range(0, 1));
      step();
    end
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || q_track !== 1'b1 || S_n !== 1'b1 || R_n !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: done,q,S_n,R_n=%b%b%b%b expected 1111", done, q_track, S_n, R_n);
    end
    step();
    step();
    for (int c = 7; c <= 9; c++) begin
      checks++;
      if (cmd_ready !== 1'b1 || S_n !== 1'b1 || R_n !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL ignore_idle cycle %0d: ready,S_n,R_n,done=%b%b%b%b expected 1110",
                 c, cmd_ready, S_n, R_n, done);
      end
      step();
    end
  endtask

  task automatic test_fast();
    logic cur_set, exp_s, exp_r, odd;
    int accepts;
    accepts = 0;
    cur_set = 1'b1;
    cmd_valid2 = 1'b1; cmd_set2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (cmd_ready2 === 1'b1) accepts++;
      step();
      odd   = k[0];
      exp_s = !(odd && cur_set);
      exp_r = !(odd && !cur_set);
      checks++;
      if (S_n2 !== exp_s || R_n2 !== exp_r || cmd_ready2 !== !odd || done2 !== !odd) begin
        errors++;
        $display("FAIL fast cycle %0d: S_n,R_n,ready,done=%b%b%b%b expected %b%b%b%b",
                 k, S_n2, R_n2, cmd_ready2, done2, exp_s, exp_r, !odd, !odd);
      end
      if (!odd) begin
        checks++;
        if (q_track2 !== cur_set) begin
          errors++;
          $display("FAIL fast_q cycle %0d: got %b expected %b", k, q_track2, cur_set);
        end
        cur_set = ~cur_set;
      end else begin
        cmd_set2 = ~cur_set;
      end
    end
    cmd_valid2 = 1'b0;
    checks++;
    if (accepts != 4) begin
      errors++;
      $display("FAIL fast_rate: %0d accepts in 8 cycles expected 4", accepts);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_set_sequence();
    test_skip();
    test_back_to_back();
    test_reset_mid_pulse();
    test_ignore_busy();
    test_fast();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d commands never completed expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 SHALL have parameter PULSE_W, default 4, giving the active-low pulse width in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter GAP_W, default 2, giving the minimum idle cycles (both outputs high) after each pulse (legal range 0..255).
REQ-003 SHALL have parameter SKIP_REDUNDANT, default 1; when 1, a command matching the tracked latch state completes without a pulse.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_set, input, 1, command value: 1 = set (Q to 1), 0 = reset (Q to 0).
REQ-008 SHALL have port cmd_ready, output, 1, the block can accept a command this cycle.
REQ-009 SHALL have port S_n, output, 1, active-low set drive toward the latch.
REQ-010 SHALL have port R_n, output, 1, active-low reset drive toward the latch.
REQ-011 SHALL have port q_track, output, 1, the latch state implied by the last completed command.
REQ-012 SHALL have port done, output, 1, single-cycle strobe when a command completes.

Function
REQ-013 SHALL accept a command on any rising clk edge where cmd_valid and cmd_ready are both 1; cmd_set is sampled on that edge.
REQ-014 SHALL implement FSM states IDLE, PULSE_S, PULSE_R, GAP; cmd_ready is 1 only in IDLE.
REQ-015 IDLE: on acceptance, go to PULSE_S (cmd_set=1) or PULSE_R (cmd_set=0), unless the redundant skip of REQ-019 applies; otherwise stay in IDLE.
REQ-016 PULSE_S: S_n is low and R_n is high for exactly PULSE_W cycles, with S_n going low the cycle after acceptance; then go to GAP.
REQ-017 PULSE_R: R_n is low and S_n is high for exactly PULSE_W cycles; then go to GAP.
REQ-018 GAP: both outputs are high for GAP_W cycles, then go to IDLE. When GAP_W=0, go directly from pulse to IDLE.
REQ-019 With SKIP_REDUNDANT=1, if cmd_set equals q_track at acceptance, stay in IDLE, produce no pulse, and assert done on the following cycle.
REQ-020 S_n and R_n SHALL never be low in the same cycle, and SHALL be registered outputs (glitch-free).
REQ-021 On the last pulse cycle, q_track SHALL update to the commanded value, and done SHALL assert for 1 cycle in the cycle after that last pulse cycle.
REQ-022 The pulse/gap counter SHALL be 8 bits wide, load PULSE_W-1 or GAP_W-1 on entry to a state, and decrement to 0; it SHALL never wrap.
REQ-023 cmd_valid and cmd_set SHALL be ignored outside IDLE; no queuing occurs, so a requester holds cmd_valid until it sees cmd_ready.
REQ-024 Best-case throughput is one command per PULSE_W+GAP_W+1 cycles.

Reset
REQ-025 While rst_n is low: state=IDLE, S_n=1, R_n=1, q_track=0, done=0, counter=0; cmd_ready SHALL be 0 during reset and 1 from the first clock edge after rst_n deasserts.
REQ-026 Reset asserted mid-pulse SHALL immediately (asynchronously) release S_n/R_n high and abandon the command without asserting done.

Structure
REQ-027 The FSM state enum and the counter width constant (8) SHALL live in a shared package, sr_pkg.
REQ-028 SHALL be a single flat module; the width counter is inline, and no sub-module is required.

Verification
REQ-029 After reset, cmd_set=1 accepted at cycle 0: S_n low in cycles 1-4, both outputs high in cycles 5-6, done=1 and q_track=1 at cycle 5, cmd_ready=1 at cycle 7.
REQ-030 With q_track=1, issue cmd_set=1 (SKIP_REDUNDANT=1): no pulse occurs, done at the next cycle, and cmd_ready never drops.
REQ-031 Set then reset back-to-back with cmd_valid held: R_n goes low exactly PULSE_W+GAP_W+1 cycles after the S_n fall, and S_n/R_n are never low together.
REQ-032 Assert rst_n low in the 2nd cycle of PULSE_R: R_n goes high without waiting for a clock, there is no done, q_track=0, and cmd_ready=1 after release.
REQ-033 With PULSE_W=1 and GAP_W=0: 1-cycle pulses and a command accepted every 2 cycles.
REQ-034 Drive cmd_valid toggling during PULSE_S with cmd_set changing: the pulse is unaffected and only the command accepted in IDLE is executed.
